// File: rtl/lookupflow_pkg.sv
// Shared definitions for the flow-lookup requester: key layout, frame byte
// offsets, IPv4 ethertype and the requester FSM state encoding.
package lookupflow_pkg;

  // Lookup key layout: {port, src MAC, src IP, dst IP}
  localparam int unsigned KEY_W        = 116;
  localparam int unsigned KEY_PORT_W   = 4;
  localparam int unsigned KEY_MAC_W    = 48;
  localparam int unsigned KEY_IP_W     = 32;
  localparam int unsigned KEY_PORT_LSB = 112;
  localparam int unsigned KEY_MAC_LSB  = 64;
  localparam int unsigned KEY_SIP_LSB  = 32;
  localparam int unsigned KEY_DIP_LSB  = 0;

  localparam logic [15:0] ETH_TYPE_IPV4 = 16'h0800;

  // Byte offsets within the frame (byte 0 = dst MAC MSB)
  localparam logic [5:0] OFF_SRC_MAC = 6'd6;
  localparam logic [5:0] OFF_ETH_HI  = 6'd12;
  localparam logic [5:0] OFF_ETH_LO  = 6'd13;
  localparam logic [5:0] OFF_SRC_IP  = 6'd26;
  localparam logic [5:0] OFF_DST_IP  = 6'd30;
  localparam logic [5:0] OFF_LAST    = 6'd33;

  typedef enum logic [2:0] {
    StIdle,
    StParse,
    StReq,
    StResult,
    StDrain
  } lookup_state_e;

endpackage

// File: rtl/lookup_key_capture.sv
// Byte counter and field capture for the lookup key. Fields are shifted in
// big-endian as their bytes arrive; the final dst IP byte is taken straight
// from the bus so the key is complete on the edge that carries byte 33.
module lookup_key_capture
  import lookupflow_pkg::*;
#(
  parameter logic [3:0] INGRESS_PORT = 4'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,   // byte 0 seen in IDLE
  input  logic             parse_i,   // FSM is in PARSE
  input  logic             rx_dv_i,
  input  logic [7:0]       rx_data_i,
  output logic [KEY_W-1:0] key_o,
  output logic             key_done_o,
  output logic             non_ip_o,
  output logic             runt_o
);

  logic [5:0]  cnt_q, cnt_d;
  logic [47:0] mac_q, mac_d;
  logic [7:0]  eth_hi_q, eth_hi_d;
  logic [31:0] sip_q, sip_d;
  logic [23:0] dip_q, dip_d;
  logic        byte_ok;

  assign byte_ok = parse_i && rx_dv_i;

  // Count bytes and shift each field in while its offset window is open
  always_comb begin
    cnt_d    = cnt_q;
    mac_d    = mac_q;
    eth_hi_d = eth_hi_q;
    sip_d    = sip_q;
    dip_d    = dip_q;
    if (start_i) begin
      cnt_d = 6'd1;
    end else if (byte_ok) begin
      cnt_d = cnt_q + 6'd1;
      if (cnt_q >= OFF_SRC_MAC && cnt_q < OFF_ETH_HI) mac_d = {mac_q[39:0], rx_data_i};
      if (cnt_q == OFF_ETH_HI) eth_hi_d = rx_data_i;
      if (cnt_q >= OFF_SRC_IP && cnt_q < OFF_DST_IP) sip_d = {sip_q[23:0], rx_data_i};
      if (cnt_q >= OFF_DST_IP && cnt_q < OFF_LAST) dip_d = {dip_q[15:0], rx_data_i};
    end
  end

  // Capture state registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      mac_q    <= '0;
      eth_hi_q <= '0;
      sip_q    <= '0;
      dip_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
      eth_hi_q <= eth_hi_d;
      sip_q    <= sip_d;
      dip_q    <= dip_d;
    end
  end

  assign key_o      = {INGRESS_PORT, mac_q, sip_q, dip_q, rx_data_i};
  assign key_done_o = byte_ok && (cnt_q == OFF_LAST);
  assign non_ip_o   = byte_ok && (cnt_q == OFF_ETH_LO) && ({eth_hi_q, rx_data_i} != ETH_TYPE_IPV4);
  assign runt_o     = parse_i && !rx_dv_i;

endmodule

// File: rtl/lookup_requester.sv
// Initiator side of the flow-lookup handshake: parses an ingress frame,
// issues a key lookup and emits one forwarding descriptor per frame.
// Optional build macro LOOKUP_TIMEOUT_EN bounds the ack wait to
// TIMEOUT_CYCLES and reports an expiry as a dropped, errored frame.
module lookup_requester
  import lookupflow_pkg::*;
#(
  parameter logic [3:0] INGRESS_PORT = 4'h0
`ifdef LOOKUP_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 16
`endif
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  input  logic             rx_dv,
  input  logic [7:0]       rx_data,
  output logic             of_lookup_req,
  output logic [KEY_W-1:0] of_lookup_data,
  input  logic             of_lookup_ack,
  input  logic             of_lookup_err,
  input  logic [3:0]       of_lookup_fwd_port,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [3:0]       res_fwd_port,
  output logic             res_drop,
  output logic             res_err,
  output logic [15:0]      ovr_cnt
);

  lookup_state_e    state_q, state_d;
  logic             req_q, req_d;
  logic [KEY_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic [3:0]       fwd_q, fwd_d;
  logic             drop_q, drop_d;
  logic             err_q, err_d;
  logic [15:0]      ovr_q, ovr_d;
  logic             rx_dv_q;
  logic             rx_rise;
  logic             busy;

  logic [KEY_W-1:0] key;
  logic             key_done;
  logic             non_ip;
  logic             runt;

`ifdef LOOKUP_TIMEOUT_EN
  localparam logic [15:0] WaitLast = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] wait_q, wait_d;
`endif

  lookup_key_capture #(
    .INGRESS_PORT(INGRESS_PORT)
  ) u_capture (
    .clk_i     (sys_clk),
    .rst_i     (sys_rst),
    .start_i   ((state_q == StIdle) && rx_dv),
    .parse_i   (state_q == StParse),
    .rx_dv_i   (rx_dv),
    .rx_data_i (rx_data),
    .key_o     (key),
    .key_done_o(key_done),
    .non_ip_o  (non_ip),
    .runt_o    (runt)
  );

  assign rx_rise = rx_dv && !rx_dv_q;
  assign busy    = (state_q == StReq) || (state_q == StResult) || (state_q == StDrain);

  // Next state and next registered outputs; outputs only move on state entry
  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    data_d  = data_q;
    valid_d = valid_q;
    fwd_d   = fwd_q;
    drop_d  = drop_q;
    err_d   = err_q;
    ovr_d   = ovr_q;
`ifdef LOOKUP_TIMEOUT_EN
    wait_d  = wait_q;
`endif

    // A frame that starts while we are still busy is skipped (drained)
    if (busy && rx_rise && (ovr_q != 16'hFFFF)) ovr_d = ovr_q + 16'd1;

    unique case (state_q)
      StIdle: begin
        if (rx_dv) state_d = StParse;
      end
      StParse: begin
        if (key_done) begin
          data_d  = key;
          req_d   = 1'b1;
          state_d = StReq;
`ifdef LOOKUP_TIMEOUT_EN
          wait_d  = '0;
`endif
        end else if (runt || non_ip) begin
          valid_d = 1'b1;
          drop_d  = 1'b1;
          err_d   = 1'b0;
          fwd_d   = '0;
          state_d = StResult;
        end
      end
      StReq: begin
        if (of_lookup_ack) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          state_d = StResult;
          if (of_lookup_err) begin
            drop_d = 1'b1;
            err_d  = 1'b1;
            fwd_d  = '0;
          end else if (of_lookup_fwd_port == 4'h0) begin
            drop_d = 1'b1;
            err_d  = 1'b0;
            fwd_d  = '0;
          end else begin
            drop_d = 1'b0;
            err_d  = 1'b0;
            fwd_d  = of_lookup_fwd_port;
          end
        end
`ifdef LOOKUP_TIMEOUT_EN
        // An ack on the expiry edge takes the branch above
        else if (wait_q == WaitLast) begin
          req_d   = 1'b0;
          valid_d = 1'b1;
          drop_d  = 1'b1;
          err_d   = 1'b1;
          fwd_d   = '0;
          state_d = StResult;
        end else begin
          wait_d = wait_q + 16'd1;
        end
`endif
      end
      StResult: begin
        if (res_ready) begin
          valid_d = 1'b0;
          state_d = rx_dv ? StDrain : StIdle;
        end
      end
      StDrain: begin
        if (!rx_dv) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and registered outputs
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      fwd_q   <= '0;
      drop_q  <= 1'b0;
      err_q   <= 1'b0;
      ovr_q   <= '0;
      rx_dv_q <= 1'b0;
`ifdef LOOKUP_TIMEOUT_EN
      wait_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      fwd_q   <= fwd_d;
      drop_q  <= drop_d;
      err_q   <= err_d;
      ovr_q   <= ovr_d;
      rx_dv_q <= rx_dv;
`ifdef LOOKUP_TIMEOUT_EN
      wait_q  <= wait_d;
`endif
    end
  end

  assign of_lookup_req  = req_q;
  assign of_lookup_data = data_q;
  assign res_valid      = valid_q;
  assign res_fwd_port   = fwd_q;
  assign res_drop       = drop_q;
  assign res_err        = err_q;
  assign ovr_cnt        = ovr_q;

endmodule

// File: tb/tb_lookup_requester.sv
// Scoreboard bench for lookup_requester: frames are generated from field
// values, expected keys/descriptors are derived from the frame rules and
// queued; a responder model and a descriptor monitor check them.
module tb_lookup_requester;

  localparam int TIMEOUT = 16;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         rx_dv;
  logic [7:0]   rx_data;
  logic         of_lookup_req;
  logic [115:0] of_lookup_data;
  logic         of_lookup_ack;
  logic         of_lookup_err;
  logic [3:0]   of_lookup_fwd_port;
  logic         res_valid;
  logic         res_ready;
  logic [3:0]   res_fwd_port;
  logic         res_drop;
  logic         res_err;
  logic [15:0]  ovr_cnt;

  lookup_requester dut (
    .sys_clk           (sys_clk),
    .sys_rst           (sys_rst),
    .rx_dv             (rx_dv),
    .rx_data           (rx_data),
    .of_lookup_req     (of_lookup_req),
    .of_lookup_data    (of_lookup_data),
    .of_lookup_ack     (of_lookup_ack),
    .of_lookup_err     (of_lookup_err),
    .of_lookup_fwd_port(of_lookup_fwd_port),
    .res_valid         (res_valid),
    .res_ready         (res_ready),
    .res_fwd_port      (res_fwd_port),
    .res_drop          (res_drop),
    .res_err           (res_err),
    .ovr_cnt           (ovr_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [3:0] fwd;
    logic       drop;
    logic       err;
  } desc_t;

  typedef struct {
    logic [115:0] key;
    logic         err;
    logic [3:0]   fwd;
    int           delay;
    bit           dbl;
    bit           noack;
  } lk_t;

  desc_t desc_q[$];
  lk_t   lk_q[$];
  int    n_cmp = 0;
  int    n_bad = 0;
  int    cyc = 0;
  int    key_edge = 0;
  int    req_cyc = 0;
  bit    chk_lat = 1'b0;
  bit    lat_pending = 1'b0;
  int    rdy_mode = 0;
  int    ovr_exp = 0;

  always @(posedge sys_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic send_frame(input int len, input logic [47:0] mac, input logic [15:0] et,
                            input logic [31:0] sip, input logic [31:0] dip);
    logic [7:0] b;
    for (int i = 0; i < len; i++) begin
      if (i >= 6 && i <= 11)       b = mac[8*(11-i) +: 8];
      else if (i == 12)            b = et[15:8];
      else if (i == 13)            b = et[7:0];
      else if (i >= 26 && i <= 29) b = sip[8*(29-i) +: 8];
      else if (i >= 30 && i <= 33) b = dip[8*(33-i) +: 8];
      else                         b = 8'($urandom);
      @(posedge sys_clk); #1;
      rx_dv   = 1'b1;
      rx_data = b;
      if (i == 33) key_edge = cyc + 1;
    end
    @(posedge sys_clk); #1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
  endtask

  task automatic drain_wait();
    int n;
    n = 0;
    while ((desc_q.size() != 0 || lk_q.size() != 0) && n < 3000) begin
      @(posedge sys_clk);
      n++;
    end
    if (n >= 3000) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain_timeout: %0d descriptors and %0d lookups still pending",
               desc_q.size(), lk_q.size());
      desc_q.delete();
      lk_q.delete();
    end
    repeat (3) @(posedge sys_clk);
    #1;
  endtask

  // Model: a lookup happens only for an IPv4 frame that reaches byte 33
  task automatic run_frame(input int len, input logic [47:0] mac, input logic [15:0] et,
                           input logic [31:0] sip, input logic [31:0] dip, input logic err,
                           input logic [3:0] fwd, input int delay, input bit dbl,
                           input bit noack, input bit wait_done);
    lk_t   l;
    desc_t d;
    if (len >= 34 && et == 16'h0800) begin
      l.key   = {4'h0, mac, sip, dip};
      l.err   = err;
      l.fwd   = fwd;
      l.delay = delay;
      l.dbl   = dbl;
      l.noack = noack;
      lk_q.push_back(l);
      if (noack || err)      d = '{fwd: 4'h0, drop: 1'b1, err: 1'b1};
      else if (fwd == 4'h0)  d = '{fwd: 4'h0, drop: 1'b1, err: 1'b0};
      else                   d = '{fwd: fwd,  drop: 1'b0, err: 1'b0};
    end else begin
      d = '{fwd: 4'h0, drop: 1'b1, err: 1'b0};
    end
    desc_q.push_back(d);
    send_frame(len, mac, et, sip, dip);
    if (wait_done) drain_wait();
  endtask

  // Flow-table responder model
  initial begin : responder
    lk_t cur;
    int  hi;
    of_lookup_ack      = 1'b0;
    of_lookup_err      = 1'b0;
    of_lookup_fwd_port = 4'h0;
    forever begin
      @(posedge sys_clk); #1;
      if (!sys_rst && of_lookup_req) begin
        if (lk_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_req: request with no lookup expected (cycle %0d)", cyc);
          hi = 0;
          while (of_lookup_req && hi < 2000) begin
            @(posedge sys_clk); #1;
            hi++;
          end
        end else begin
          cur = lk_q.pop_front();
          check("lookup_key", 128'(of_lookup_data), 128'(cur.key));
          if (chk_lat) begin
            check("req_latency", 128'(cyc), 128'(key_edge));
            req_cyc     = cyc;
            lat_pending = 1'b1;
            chk_lat     = 1'b0;
          end
          if (cur.noack) begin
            hi = 1;
            while (hi < 1000) begin
              @(posedge sys_clk); #1;
              if (!of_lookup_req) break;
              hi++;
            end
            check("timeout_req_cycles", 128'(hi), 128'(TIMEOUT));
          end else begin
            for (int i = 0; i < cur.delay; i++) begin
              @(posedge sys_clk); #1;
              check("req_held", 128'(of_lookup_req), 128'(1));
              check("key_held", 128'(of_lookup_data), 128'(cur.key));
            end
            @(posedge sys_clk); #1;
            of_lookup_ack      = 1'b1;
            of_lookup_err      = cur.err;
            of_lookup_fwd_port = cur.fwd;
            @(posedge sys_clk); #1;
            check("req_drop_after_ack", 128'(of_lookup_req), 128'(0));
            if (cur.dbl) begin
              // Second ack carries different content; it must be ignored
              of_lookup_err      = ~cur.err;
              of_lookup_fwd_port = ~cur.fwd;
              @(posedge sys_clk); #1;
            end
            of_lookup_ack      = 1'b0;
            of_lookup_err      = 1'b0;
            of_lookup_fwd_port = 4'h0;
          end
        end
      end
    end
  end

  // Descriptor monitor
  initial begin : monitor
    desc_t prev;
    desc_t got;
    desc_t exp;
    bit    pv;
    bit    phs;
    pv   = 1'b0;
    phs  = 1'b0;
    prev = '0;
    forever begin
      @(negedge sys_clk);
      got = '{fwd: res_fwd_port, drop: res_drop, err: res_err};
      if (!sys_rst) begin
        if (res_valid && pv && !phs) check("desc_stable", 128'(got), 128'(prev));
        if (res_valid && !pv && lat_pending) begin
          check("res_latency", 128'(cyc), 128'(req_cyc + 2));
          lat_pending = 1'b0;
        end
        if (res_valid && res_ready) begin
          if (desc_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected_desc: got %0h with none expected (cycle %0d)", got, cyc);
          end else begin
            exp = desc_q.pop_front();
            check("descriptor", 128'(got), 128'(exp));
          end
        end
      end
      pv   = res_valid;
      phs  = res_valid && res_ready;
      prev = got;
    end
  end

  // res_ready: 0 = always ready, 1 = held low, else random
  initial begin : ready_drv
    res_ready = 1'b0;
    forever begin
      @(posedge sys_clk); #1;
      case (rdy_mode)
        0:       res_ready = 1'b1;
        1:       res_ready = 1'b0;
        default: res_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded its time limit (cycle %0d)", cyc);
    $fatal(1, "watchdog expired");
  end

  localparam logic [47:0] MAC0 = 48'h406c8f37f1f8;

  initial begin : main
    sys_rst = 1'b1;
    rx_dv   = 1'b0;
    rx_data = 8'h00;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_req", 128'(of_lookup_req), 128'(0));
    check("rst_data", 128'(of_lookup_data), 128'(0));
    check("rst_valid", 128'(res_valid), 128'(0));
    check("rst_fwd", 128'(res_fwd_port), 128'(0));
    check("rst_drop", 128'(res_drop), 128'(0));
    check("rst_err", 128'(res_err), 128'(0));
    check("rst_ovr", 128'(ovr_cnt), 128'(0));
    sys_rst = 1'b0;
    repeat (2) @(posedge sys_clk);
    #1;

    // Lookup hit with latency checks
    chk_lat = 1'b1;
    run_frame(40, MAC0, 16'h0800, 32'h0A0000C8, 32'h0A000003, 1'b0, 4'b0100, 0, 0, 0, 1);
    // Lookup miss
    run_frame(40, MAC0, 16'h0800, 32'h0A0000C8, 32'h0A000009, 1'b1, 4'b0100, 0, 0, 0, 1);
    // ARP frame: no request
    run_frame(60, MAC0, 16'h0806, 32'h0A0000C8, 32'h0A000003, 1'b0, 4'b0001, 0, 0, 0, 1);
    // Runt
    run_frame(20, MAC0, 16'h0800, 32'h0A0000C8, 32'h0A000003, 1'b0, 4'b0001, 0, 0, 0, 1);
    // Hit with empty mask is a drop
    run_frame(40, MAC0, 16'h0800, 32'h0A000001, 32'h0A000002, 1'b0, 4'h0, 1, 0, 0, 1);

    // Overrun: descriptor held, second frame skipped, third parsed
    rdy_mode = 1;
    run_frame(40, MAC0, 16'h0800, 32'h0A000005, 32'h0A000006, 1'b0, 4'b0010, 0, 0, 0, 0);
    repeat (3) @(posedge sys_clk);
    #1;
    send_frame(40, 48'h112233445566, 16'h0800, 32'hC0A80001, 32'hC0A80002);
    ovr_exp++;
    repeat (10) @(posedge sys_clk);
    #1;
    check("ovr_cnt_after_skip", 128'(ovr_cnt), 128'(ovr_exp));
    rdy_mode = 0;
    drain_wait();
    run_frame(40, 48'h0a0b0c0d0e0f, 16'h0800, 32'h0A000007, 32'h0A000008, 1'b0, 4'b1000, 0, 0, 0,
              1);

    // Double ack: one descriptor, first ack's content
    run_frame(48, MAC0, 16'h0800, 32'h0A0000C8, 32'h0A000004, 1'b0, 4'b1010, 0, 1, 0, 1);

`ifdef LOOKUP_TIMEOUT_EN
    run_frame(40, MAC0, 16'h0800, 32'h0A0000C8, 32'h0A00000A, 1'b0, 4'b0101, 0, 0, 1, 1);
    // Ack on the expiry edge wins
    run_frame(40, MAC0, 16'h0800, 32'h0A0000C8, 32'h0A00000B, 1'b0, 4'b0110, TIMEOUT - 2, 0, 0,
              1);
`endif

    // Randomized frames with random back-pressure
    rdy_mode = 2;
    for (int f = 0; f < 40; f++) begin
      int          len;
      logic [15:0] et;
      len = int'($urandom_range(10, 64));
      et  = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(0, 65535)) : 16'h0800;
      run_frame(len, 48'({$urandom, $urandom}), et, 32'($urandom), 32'($urandom),
                1'($urandom_range(0, 3) == 0), 4'($urandom), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'b0, 1);
    end
    rdy_mode = 0;
    repeat (5) @(posedge sys_clk);
    #1;
    check("ovr_cnt_final", 128'(ovr_cnt), 128'(ovr_exp));
    check("req_idle_final", 128'(of_lookup_req), 128'(0));
    check("valid_idle_final", 128'(res_valid), 128'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
